// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory-port arbiter: FSM states,
// request owner and the MemOp codes the core puts on the memory port.
package mem_port_arbiter_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef logic [2:0] mem_op_t;

  localparam mem_op_t MEMOP_LB  = 3'd0;
  localparam mem_op_t MEMOP_LH  = 3'd1;
  localparam mem_op_t MEMOP_LW  = 3'd2;
  localparam mem_op_t MEMOP_LD  = 3'd3;
  localparam mem_op_t MEMOP_LBU = 3'd4;
  localparam mem_op_t MEMOP_LHU = 3'd5;
  localparam mem_op_t MEMOP_LWU = 3'd6;

  // Instruction fetches always go out as a 32-bit load.
  localparam mem_op_t IF_MEM_OP = MEMOP_LW;

  // Picks the 32-bit instruction out of the aligned 64-bit memory word.
  function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] w);
    return hi ? w[63:32] : w[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Winner selection between fetch and load/store: LS has fixed priority, but
// after MAX_CONSEC back-to-back LS grants with a fetch waiting, IF goes first.
module arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic ls_req,
  output logic if_gnt,
  output logic ls_gnt
);

  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);

  logic [CW-1:0] consec;
  logic          if_starved;

  assign if_starved = (consec == CONSEC_MAX) && if_req;

  always_comb begin
    ls_gnt = arb_en && ls_req && !if_starved;
    if_gnt = arb_en && if_req && !ls_gnt;
  end

  // Only LS grants that actually bypass a waiting fetch count toward starvation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec <= '0;
    end else if (if_gnt) begin
      consec <= '0;
    end else if (ls_gnt) begin
      if (!if_req)
        consec <= '0;
      else if (consec != CONSEC_MAX)
        consec <= consec + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by instruction fetch and load/store,
// with per-transaction timeout abort and registered response steering.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [31:0]     if_rdata,
  input  logic            ls_req,
  input  logic [XLEN-1:0] ls_addr,
  input  logic            ls_wen,
  input  logic [2:0]      ls_op,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            rsp_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [2:0]      mem_op,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  // The abort is decided on the last waiting cycle so the error response
  // lands exactly TIMEOUT cycles after the grant cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 2);

  arb_state_e state, state_nxt;
  owner_e     owner;
  logic [7:0] tcnt;
  logic       arb_en;
  logic       grant;
  logic       tmo;
  logic       complete;
  logic       abort;
  logic       finish;

  assign arb_en = rst_n && (state == ST_IDLE);
  assign grant  = if_gnt || ls_gnt;
  assign tmo    = (tcnt == TMO_LAST);
  assign finish = complete || abort;

  arb_select #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_arb_select (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_en (arb_en),
    .if_req (if_req),
    .ls_req (ls_req),
    .if_gnt (if_gnt),
    .ls_gnt (ls_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (grant) state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (mem_ready && mem_rvalid) state_nxt = ST_IDLE;
        else if (tmo)                state_nxt = ST_IDLE;
        else if (mem_ready)          state_nxt = ST_DATA;
      end
      ST_DATA: if (mem_rvalid || tmo) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_valid = (state == ST_ADDR);
    busy      = (state != ST_IDLE);
    complete  = ((state == ST_ADDR) && mem_ready && mem_rvalid) ||
                ((state == ST_DATA) && mem_rvalid);
    abort     = busy && tmo && !complete;
  end

  // Request latch: fields are captured on the grant edge and held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_IF;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_op    <= '0;
      mem_wdata <= '0;
    end else if (ls_gnt) begin
      owner     <= OWN_LS;
      mem_addr  <= ls_addr;
      mem_wen   <= ls_wen;
      mem_op    <= ls_op;
      mem_wdata <= ls_wdata;
    end else if (if_gnt) begin
      owner     <= OWN_IF;
      mem_addr  <= if_addr;
      mem_wen   <= 1'b0;
      mem_op    <= IF_MEM_OP;
      mem_wdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tcnt <= '0;
    else if (grant)  tcnt <= '0;
    else if (busy)   tcnt <= tcnt + 8'd1;
  end

  // Response stage: one-cycle rvalid to the owner, data zeroed on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      rsp_err   <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= finish && (owner == OWN_IF);
      ls_rvalid <= finish && (owner == OWN_LS);
      rsp_err   <= abort;
      if (finish && (owner == OWN_IF))
        if_rdata <= abort ? '0 : fetch_word(mem_addr[2], mem_rdata[63:0]);
      if (finish && (owner == OWN_LS))
        ls_rdata <= abort ? '0 : mem_rdata;
    end
  end

endmodule
